// File: rtl/poly_voice_pkg.sv
// Shared types for the poly_voice engine: amplitude width and the
// per-voice envelope state encoding.
package poly_voice_pkg;

  localparam int AMPLITUDE_BITS = 24;
  localparam int ENV_STATE_BITS = 3;

  typedef logic [AMPLITUDE_BITS-1:0] amplitude_t;

  typedef enum logic [ENV_STATE_BITS-1:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_t;

  localparam amplitude_t AMP_MAX = '1;

  // Voices in these states respond to a note-off.
  function automatic logic is_held(input env_state_t s);
    return (s == ENV_ATTACK) || (s == ENV_DECAY) || (s == ENV_SUSTAIN);
  endfunction

endpackage

// File: rtl/poly_voice_env_step.sv
// One linear ADSR envelope step (combinational). Used once per voice
// per sweep.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | voice free, env held at 0
//   ATTACK  | env rises by attack_rate, saturates at all-ones -> DECAY
//   DECAY   | env falls by decay_rate until <= sustain -> SUSTAIN
//   SUSTAIN | env follows the live sustain input
//   RELEASE | env falls by release_rate, reaching 0 -> IDLE
module poly_voice_env_step
  import poly_voice_pkg::*;
(
  input  logic [ENV_STATE_BITS-1:0] state_i,
  input  logic [AMPLITUDE_BITS-1:0] env_i,
  input  logic [AMPLITUDE_BITS-1:0] attack_rate,
  input  logic [AMPLITUDE_BITS-1:0] decay_rate,
  input  logic [AMPLITUDE_BITS-1:0] release_rate,
  input  logic [AMPLITUDE_BITS-1:0] sustain,
  output logic [ENV_STATE_BITS-1:0] state_o,
  output logic [AMPLITUDE_BITS-1:0] env_o
);

  logic [AMPLITUDE_BITS:0] attack_sum;
  logic [AMPLITUDE_BITS:0] decay_diff;
  env_state_t              state_cur;
  env_state_t              state_nxt;

  assign state_cur  = env_state_t'(state_i);
  assign attack_sum = {1'b0, env_i} + {1'b0, attack_rate};
  assign decay_diff = {1'b0, env_i} - {1'b0, decay_rate};
  assign state_o    = state_nxt;

  // Next envelope state and level for one sweep.
  always_comb begin
    state_nxt = state_cur;
    env_o     = env_i;
    case (state_cur)
      ENV_ATTACK: begin
        if (attack_sum >= {1'b0, AMP_MAX}) begin
          env_o     = AMP_MAX;
          state_nxt = ENV_DECAY;
        end else begin
          env_o = attack_sum[AMPLITUDE_BITS-1:0];
        end
      end
      ENV_DECAY: begin
        // Borrow out of the top bit means the step went below zero.
        if (decay_diff[AMPLITUDE_BITS] || (decay_diff[AMPLITUDE_BITS-1:0] <= sustain)) begin
          env_o     = sustain;
          state_nxt = ENV_SUSTAIN;
        end else begin
          env_o = decay_diff[AMPLITUDE_BITS-1:0];
        end
      end
      ENV_SUSTAIN: begin
        env_o = sustain;
      end
      ENV_RELEASE: begin
        if (env_i <= release_rate) begin
          env_o     = '0;
          state_nxt = ENV_IDLE;
        end else begin
          env_o = env_i - release_rate;
        end
      end
      default: begin
        state_nxt = state_cur;
        env_o     = env_i;
      end
    endcase
  end

endmodule

// File: rtl/poly_voice.sv
// Time-multiplexed polyphonic sawtooth voice engine with per-voice ADSR.
// A sample_strobe starts a sweep that walks the voices one per cycle
// through a read/update, multiply, accumulate pipeline and registers the
// mixed sample at strobe + VOICES + 3.
// Build option: POLY_VOICE_SATURATE_EN selects a clamped full-scale sum
// instead of dividing the mix by the voice count.
module poly_voice
  import poly_voice_pkg::*;
#(
  parameter int VOICES     = 4,
  parameter int PHASE_BITS = 32,
  parameter int ID_BITS    = 7
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      sample_strobe,
  input  logic                      note_valid,
  output logic                      note_ready,
  input  logic                      note_on,
  input  logic [ID_BITS-1:0]        note_id,
  input  logic [PHASE_BITS-1:0]     note_inc,
  input  logic [AMPLITUDE_BITS-1:0] attack_rate,
  input  logic [AMPLITUDE_BITS-1:0] decay_rate,
  input  logic [AMPLITUDE_BITS-1:0] release_rate,
  input  logic [AMPLITUDE_BITS-1:0] sustain,
  output logic [AMPLITUDE_BITS-1:0] out,
  output logic                      out_valid,
  output logic [VOICES-1:0]         active_mask,
  output logic                      overrun
);

  localparam int VIDX_BITS = $clog2(VOICES);
  localparam int ACC_BITS  = AMPLITUDE_BITS + VIDX_BITS;
  localparam int CYC_BITS  = $clog2(VOICES + 4);

  // Sweep cycle counter: 0 = idle, k = k cycles after the strobe.
  localparam logic [CYC_BITS-1:0] CYC_ONE       = CYC_BITS'(1);
  localparam logic [CYC_BITS-1:0] CYC_RD_LAST   = CYC_BITS'(VOICES);
  localparam logic [CYC_BITS-1:0] CYC_MUL_FIRST = CYC_BITS'(2);
  localparam logic [CYC_BITS-1:0] CYC_MUL_LAST  = CYC_BITS'(VOICES + 1);
  localparam logic [CYC_BITS-1:0] CYC_ACC_FIRST = CYC_BITS'(3);
  localparam logic [CYC_BITS-1:0] CYC_ACC_LAST  = CYC_BITS'(VOICES + 2);
  localparam logic [CYC_BITS-1:0] CYC_LAST      = CYC_BITS'(VOICES + 3);

  typedef struct packed {
    env_state_t             state;
    amplitude_t             env;
    logic [PHASE_BITS-1:0]  phase;
    logic [PHASE_BITS-1:0]  inc;
    logic [ID_BITS-1:0]     id;
  } voice_t;

  voice_t                voice_q [VOICES];
  voice_t                voice_d [VOICES];
  logic [CYC_BITS-1:0]   cyc_q, cyc_d;
  logic [VIDX_BITS-1:0]  steal_q, steal_d;
  amplitude_t            s1_wave_q, s1_wave_d;
  amplitude_t            s1_env_q, s1_env_d;
  amplitude_t            prod_q, prod_d;
  logic [ACC_BITS-1:0]   acc_q, acc_d;
  amplitude_t            out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  overrun_q, overrun_d;
  logic [VOICES-1:0]     active_mask_q, active_mask_d;

  logic                  rd_en, mul_en, acc_en;
  logic [VIDX_BITS-1:0]  rd_idx;
  voice_t                cur, upd;
  logic [ENV_STATE_BITS-1:0] step_state;
  amplitude_t            step_env;
  logic                  ev_accept;
  logic                  match_found, idle_found;
  logic [VIDX_BITS-1:0]  match_idx, idle_idx, alloc_idx;
  logic [ACC_BITS-1:0]   acc_sum;

  assign note_ready  = (cyc_q == '0);
  assign ev_accept   = note_valid && note_ready;
  assign rd_en       = (cyc_q >= CYC_ONE) && (cyc_q <= CYC_RD_LAST);
  assign mul_en      = (cyc_q >= CYC_MUL_FIRST) && (cyc_q <= CYC_MUL_LAST);
  assign acc_en      = (cyc_q >= CYC_ACC_FIRST) && (cyc_q <= CYC_ACC_LAST);
  assign rd_idx      = VIDX_BITS'(cyc_q - CYC_ONE);
  assign cur         = voice_q[rd_idx];
  assign alloc_idx   = idle_found ? idle_idx : steal_q;

  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign active_mask = active_mask_q;
  assign overrun     = overrun_q;

  poly_voice_env_step u_env_step (
    .state_i      (cur.state),
    .env_i        (cur.env),
    .attack_rate  (attack_rate),
    .decay_rate   (decay_rate),
    .release_rate (release_rate),
    .sustain      (sustain),
    .state_o      (step_state),
    .env_o        (step_env)
  );

  // Allocation search; scanning downward lets the lowest index win.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    idle_found  = 1'b0;
    idle_idx    = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if ((voice_q[i].state != ENV_IDLE) && (voice_q[i].id == note_id)) begin
        match_found = 1'b1;
        match_idx   = VIDX_BITS'(i);
      end
      if (voice_q[i].state == ENV_IDLE) begin
        idle_found = 1'b1;
        idle_idx   = VIDX_BITS'(i);
      end
    end
  end

  // Read/update stage: advance envelope and phase of the voice being swept.
  always_comb begin
    upd = cur;
    if (cur.state != ENV_IDLE) begin
      upd.state = env_state_t'(step_state);
      upd.env   = step_env;
      upd.phase = cur.phase + cur.inc;
    end
    s1_wave_d = '0;
    s1_env_d  = '0;
    if (rd_en) begin
      s1_wave_d = upd.phase[PHASE_BITS-1 -: AMPLITUDE_BITS];
      s1_env_d  = (upd.state == ENV_IDLE) ? '0 : upd.env;
    end
  end

  // Voice storage next-state: note events when idle, write-back during a sweep.
  always_comb begin
    for (int i = 0; i < VOICES; i++) voice_d[i] = voice_q[i];
    steal_d = steal_q;
    if (ev_accept) begin
      if (note_on) begin
        if (match_found) begin
          voice_d[match_idx].state = ENV_ATTACK;
        end else begin
          voice_d[alloc_idx].state = ENV_ATTACK;
          voice_d[alloc_idx].env   = '0;
          voice_d[alloc_idx].phase = '0;
          voice_d[alloc_idx].inc   = note_inc;
          voice_d[alloc_idx].id    = note_id;
          if (!idle_found) steal_d = steal_q + 1'b1;
        end
      end else begin
        for (int i = 0; i < VOICES; i++) begin
          if ((voice_q[i].id == note_id) && is_held(voice_q[i].state)) begin
            voice_d[i].state = ENV_RELEASE;
          end
        end
      end
    end
    if (rd_en) voice_d[rd_idx] = upd;
    active_mask_d = '0;
    for (int i = 0; i < VOICES; i++) active_mask_d[i] = (voice_d[i].state != ENV_IDLE);
  end

  // Sweep sequencing and overrun detection.
  always_comb begin
    cyc_d     = cyc_q;
    overrun_d = overrun_q;
    if (cyc_q == '0) begin
      if (sample_strobe) cyc_d = CYC_ONE;
    end else begin
      cyc_d = (cyc_q == CYC_LAST) ? '0 : cyc_q + CYC_ONE;
      if (sample_strobe) overrun_d = 1'b1;
    end
  end

  // Multiply and accumulate stages; the last voice's sum goes straight to out.
  always_comb begin
    prod_d = '0;
    if (mul_en) begin
      prod_d = amplitude_t'(({{AMPLITUDE_BITS{1'b0}}, s1_wave_q} *
                             {{AMPLITUDE_BITS{1'b0}}, s1_env_q}) >> AMPLITUDE_BITS);
    end
    acc_sum     = ((cyc_q == CYC_ACC_FIRST) ? '0 : acc_q) + ACC_BITS'(prod_q);
    acc_d       = acc_en ? acc_sum : acc_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (acc_en && (cyc_q == CYC_ACC_LAST)) begin
      out_valid_d = 1'b1;
`ifdef POLY_VOICE_SATURATE_EN
      out_d = (acc_sum > ACC_BITS'(AMP_MAX)) ? AMP_MAX : amplitude_t'(acc_sum);
`else
      out_d = amplitude_t'(acc_sum >> VIDX_BITS);
`endif
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < VOICES; i++) voice_q[i] <= '0;
      cyc_q         <= '0;
      steal_q       <= '0;
      s1_wave_q     <= '0;
      s1_env_q      <= '0;
      prod_q        <= '0;
      acc_q         <= '0;
      out_q         <= '0;
      out_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      active_mask_q <= '0;
    end else begin
      for (int i = 0; i < VOICES; i++) voice_q[i] <= voice_d[i];
      cyc_q         <= cyc_d;
      steal_q       <= steal_d;
      s1_wave_q     <= s1_wave_d;
      s1_env_q      <= s1_env_d;
      prod_q        <= prod_d;
      acc_q         <= acc_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
      overrun_q     <= overrun_d;
      active_mask_q <= active_mask_d;
    end
  end

endmodule

// File: doc/poly_voice.md
# poly_voice

Time-multiplexed polyphonic voice engine: VOICES independent sawtooth oscillators, each with its own linear ADSR envelope. Voices are allocated from note-on/note-off events and summed into one amplitude sample per audio tick. It replaces the single nco+adsr pair between the audio-rate clock domain and the pdm output stage, and runs on the fast clock with a one-cycle sample strobe.

## Interface
Parameters:
- VOICES, 4: voice count, power of two, 2..16
- PHASE_BITS, 32: phase accumulator width, ≥ AMPLITUDE_BITS
- ID_BITS, 7: note identifier width

Ports:
- clock  in  1  fast clock; all logic on its rising edge
- reset_n  in  1  synchronous, active-low reset
- sample_strobe  in  1  one-cycle pulse per audio sample
- note_valid  in  1  note event present
- note_ready  out  1  engine can accept an event
- note_on  in  1  1 = note-on, 0 = note-off
- note_id  in  ID_BITS  key identifier
- note_inc  in  PHASE_BITS  per-sample phase increment; used on note-on only
- attack_rate, decay_rate, release_rate  in  AMPLITUDE_BITS  per-sample envelope step, shared by all voices
- sustain  in  AMPLITUDE_BITS  sustain level
- out  out  AMPLITUDE_BITS  mixed sample, unsigned
- out_valid  out  1  one-cycle pulse when out updates
- active_mask  out  VOICES  bit i = voice i not IDLE
- overrun  out  1  sticky; strobe arrived during a sweep

## Operation
- Per-voice state: env_state {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE}, env, phase, inc, id.
- Note events are accepted on note_valid && note_ready. note_ready = 1 only when no sweep is in progress. One event is processed per cycle.
- Note-on allocation, first match wins:
  - A non-IDLE voice with the same id is retriggered: ATTACK; env, phase and inc are kept.
  - Otherwise the lowest-index IDLE voice: phase = 0, env = 0, inc = note_inc, ATTACK.
  - Otherwise the voice at steal pointer: same as an IDLE voice. The steal pointer then increments modulo VOICES.
- Note-off: every voice with a matching id in ATTACK, DECAY or SUSTAIN goes to RELEASE. No match: ignored.
- Envelope, once per sweep for each non-IDLE voice:
  - ATTACK: env += attack_rate, saturating at all-ones. On saturation → DECAY.
  - DECAY: env -= decay_rate. If the result is ≤ sustain or underflows: env = sustain → SUSTAIN.
  - SUSTAIN: env = sustain, tracking live changes to sustain.
  - RELEASE: if env ≤ release_rate: env = 0 → IDLE. Otherwise env -= release_rate.
- Phase: non-IDLE voices add phase += inc, wrapping modulo 2^PHASE_BITS. IDLE voices hold their phase.
- Voice sample = (phase[MSBs, AMPLITUDE_BITS] × env) >> AMPLITUDE_BITS, computed on the updated values. IDLE voices contribute 0.
- Mix: the accumulator is AMPLITUDE_BITS + log2(VOICES) wide. Default output = acc >> log2(VOICES).
- Reset: all voices IDLE with env/phase/inc/id = 0. Steal pointer = 0, out = 0, out_valid = 0, overrun = 0, active_mask = 0, note_ready = 1.

## Timing
- A strobe at cycle T starts a sweep. Voice i is read at T+1+i.
- Pipeline: read/update, multiply, accumulate (3 stages). Voice i state is written back at T+2+i.
- out and out_valid are registered at T+VOICES+3. out holds until the next update.
- note_ready = 0 from T+1 through T+VOICES+3.
- Strobe spacing must be ≥ VOICES+4 cycles. A strobe inside a sweep is ignored and sets overrun until reset.
- Strobe and accepted note event in the same cycle: the event is applied first and the sweep sees the new state.
- active_mask is registered and reflects state after the last write-back or event.
- Reset in the middle of a sweep aborts it; out_valid does not pulse.

## Configuration
- POLY_VOICE_SATURATE_EN defined: no divide. out = acc, clamped to all-ones when acc ≥ 2^AMPLITUDE_BITS.
- Not defined: out = acc >> log2(VOICES). Never clips.

## Structure
- mypackage: AMPLITUDE_BITS, amplitude; new env_state_t enum; voice_t struct (state, env, phase, inc, id).
- Sub-module env_step (combinational): maps state, env and rate/sustain inputs to the next state and env. Shared by the sweep pipeline and directly unit-testable.
- Voice storage is a VOICES-deep array of voice_t (registers; RAM is not required).

## Test plan
All cases use VOICES=4, PHASE_BITS=32, strobe every 64 cycles.
- After reset: out=0, active_mask=0, note_ready=1. No out_valid until the first strobe; at T+7 out=0.
- note_on id=60, inc=2^28, attack_rate=24'h100000, decay_rate=24'h080000, sustain=24'h800000, release_rate=24'h100000 → env reaches 24'hFFFFFF at sweep 16, then 24'h800000 at sweep 32. Phase MSBs ramp with a 16-sample period.
- Five note-ons with distinct ids → voices 0–3 are filled. The fifth steals voice 0 (phase 0, env 0); steal pointer = 1.
- note_on id=60 twice → only active_mask=0001 (retrigger, no second voice). note_off id=61 → no change. note_off id=60 → RELEASE; IDLE after 8 sweeps from 24'h800000.
- Two strobes 3 cycles apart → overrun=1, exactly one out_valid. reset_n=0 at sweep cycle 2 → no out_valid, all state cleared.
- Four voices at env FFFFFF with phase MSB at max → out ≈ FFFFFE without POLY_VOICE_SATURATE_EN, FFFFFF with it.
